// File: rtl/paquete_patrones.sv
// Shared definitions for the pattern generator and its receiver: FSM state
// encodings, default pattern and repetition helpers.
package paquete_patrones;

  // Generator FSM states with fixed encodings shared with the receiver.
  typedef enum logic [1:0] {
    StReposo = 2'd0,
    StEnvio  = 2'd1,
    StPausa  = 2'd2,
    StFin    = 2'd3
  } estado_t;

  // Default pattern used by both ends of the link.
  localparam logic [3:0] PATRON_DEF = 4'b1011;

  // Repetition counter width: one spare bit so the count never wraps.
  localparam int unsigned ANCHO_REP = 5;

  // A requested count of 0 still sends the word once.
  function automatic logic [ANCHO_REP-1:0] rep_efectivas(input logic [3:0] rep);
    return (rep == 4'd0) ? 5'd1 : {1'b0, rep};
  endfunction

endpackage

// File: rtl/registro_desplazamiento.sv
// Shift register plus bit counter for one serial word, MSB first.
// With GEN_PARIDAD_EN defined, an even-parity bit is appended after the
// pattern bits; otherwise the word is exactly ANCHO bits and no parity exists.
module registro_desplazamiento #(
  parameter int unsigned ANCHO = 4
) (
  input  logic             clk,
  input  logic             load,
  input  logic             shift,
  input  logic [ANCHO-1:0] data,
  output logic             msb,
  output logic             ultimo
);

`ifdef GEN_PARIDAD_EN
  localparam int unsigned BITS = ANCHO + 1;
`else
  localparam int unsigned BITS = ANCHO;
`endif
  localparam int unsigned CNT_W = $clog2(ANCHO + 1);

  logic [BITS-1:0]  r_desp;
  logic [CNT_W-1:0] r_cnt;
  logic [BITS-1:0]  w_carga;

`ifdef GEN_PARIDAD_EN
  // Parity rides in the LSB so it simply falls out after the pattern bits.
  assign w_carga = {data, ^data};
`else
  assign w_carga = data;
`endif

  // Load a fresh word or advance one bit; contents need no reset value.
  always_ff @(posedge clk) begin
    if (load) begin
      r_desp <= w_carga;
      r_cnt  <= '0;
    end else if (shift) begin
      r_desp <= {r_desp[BITS-2:0], 1'b0};
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign msb    = r_desp[BITS-1];
  assign ultimo = (r_cnt == CNT_W'(BITS - 1));

endmodule

// File: rtl/generador_patrones.sv
// Serial pattern generator: sends a latched pattern MSB first, repeated a
// latched number of times with PAUSA idle cycles in between, then pulses fin.
// Optional feature: define GEN_PARIDAD_EN to append an even-parity bit per word.
module generador_patrones
  import paquete_patrones::*;
#(
  parameter int unsigned ANCHO = 4,
  parameter int unsigned PAUSA = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iniciar,
  input  logic [ANCHO-1:0] patron,
  input  logic [3:0]       repeticiones,
  output logic             salida,
  output logic             valido,
  output logic             ocupado,
  output logic             fin
);

  // Last value of the pause counter; unused when PAUSA is 0.
  localparam logic [3:0] PAUSA_ULT = (PAUSA > 0) ? 4'(PAUSA - 1) : 4'd0;

  estado_t                r_estado;
  estado_t                w_estado_sig;
  logic [ANCHO-1:0]       r_patron;
  logic [ANCHO_REP-1:0]   r_rep;
  logic [3:0]             r_pausa;

  logic                   w_arranque;
  logic                   w_quedan;
  logic                   w_fin_pausa;
  logic                   w_carga;
  logic                   w_desplaza;
  logic [ANCHO-1:0]       w_datos;
  logic                   w_msb;
  logic                   w_ultimo;

  assign w_arranque  = (r_estado == StReposo) && iniciar;
  // r_rep counts the words still to send, including the current one.
  assign w_quedan    = (r_rep > 5'd1);
  assign w_fin_pausa = (r_pausa == PAUSA_ULT);

  registro_desplazamiento #(
    .ANCHO (ANCHO)
  ) u_registro (
    .clk    (clk),
    .load   (w_carga),
    .shift  (w_desplaza),
    .data   (w_datos),
    .msb    (w_msb),
    .ultimo (w_ultimo)
  );

  // State register with synchronous reset; reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= StReposo;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next state and shift-register control.
  always_comb begin
    w_estado_sig = r_estado;
    w_carga      = 1'b0;
    w_desplaza   = 1'b0;
    w_datos      = r_patron;
    unique case (r_estado)
      StReposo: begin
        // First word loads straight from the input, latched copy not yet valid.
        w_datos = patron;
        if (iniciar) begin
          w_estado_sig = StEnvio;
          w_carga      = 1'b1;
        end
      end
      StEnvio: begin
        if (w_ultimo) begin
          if (w_quedan) begin
            if (PAUSA == 0) begin
              w_estado_sig = StEnvio;
              w_carga      = 1'b1;
            end else begin
              w_estado_sig = StPausa;
            end
          end else begin
            w_estado_sig = StFin;
          end
        end else begin
          w_desplaza = 1'b1;
        end
      end
      StPausa: begin
        if (w_fin_pausa) begin
          w_estado_sig = StEnvio;
          w_carga      = 1'b1;
        end
      end
      StFin: begin
        w_estado_sig = StReposo;
      end
      default: begin
        w_estado_sig = StReposo;
      end
    endcase
  end

  // Latch pattern and repetitions on an accepted start; count words down.
  always_ff @(posedge clk) begin
    if (w_arranque) begin
      r_patron <= patron;
      r_rep    <= rep_efectivas(repeticiones);
    end else if ((r_estado == StEnvio) && w_ultimo && w_quedan) begin
      r_rep <= r_rep - 5'd1;
    end
  end

  // Pause counter: restarts every time the pause state is entered.
  always_ff @(posedge clk) begin
    if (r_estado != StPausa) begin
      r_pausa <= 4'd0;
    end else begin
      r_pausa <= r_pausa + 4'd1;
    end
  end

  // Moore outputs decoded from registered state and shift register.
  always_comb begin
    valido  = (r_estado == StEnvio);
    salida  = (r_estado == StEnvio) & w_msb;
    ocupado = (r_estado != StReposo);
    fin     = (r_estado == StFin);
  end

endmodule

// File: doc/generador_patrones.md
GENERADOR_PATRONES -- requirements
Module: generador_patrones

Interface
REQ-001 SHALL have parameter ANCHO, default 4, pattern width in bits (2..16).
REQ-002 SHALL have parameter PAUSA, default 1, idle cycles between repetitions (0..15).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port iniciar, input, 1, start request, sampled only in REPOSO.
REQ-006 SHALL have port patron, input, ANCHO, pattern to send, MSB first, latched on accepted start.
REQ-007 SHALL have port repeticiones, input, 4, repetition count latched on start; 0 is treated as 1.
REQ-008 SHALL have port salida, output, 1, serial data bit.
REQ-009 SHALL have port valido, output, 1, high while salida carries a pattern or parity bit.
REQ-010 SHALL have port ocupado, output, 1, high from the cycle after the accepted start through the FIN cycle.
REQ-011 SHALL have port fin, output, 1, one-cycle completion pulse.

Function
REQ-012 SHALL implement a Moore FSM with states REPOSO, ENVIO, PAUSA and FIN; all outputs SHALL be registered or decoded from registered state only.
REQ-013 SHALL accept a start when iniciar=1 in REPOSO: latch patron and repeticiones, then enter ENVIO on the next edge.
REQ-014 In ENVIO, salida SHALL present the latched bits MSB first, one bit per cycle, with valido=1; ANCHO cycles, or ANCHO+1 when parity is enabled.
REQ-015 After the last bit of a word, SHALL enter PAUSA if repetitions remain and PAUSA>0, ENVIO directly if repetitions remain and PAUSA=0, and otherwise FIN.
REQ-016 In PAUSA, SHALL hold salida=0 and valido=0 for exactly PAUSA cycles, then re-enter ENVIO starting again at the MSB.
REQ-017 In FIN, SHALL drive fin=1, valido=0 and salida=0 for one cycle, then return to REPOSO.
REQ-018 SHALL ignore iniciar outside REPOSO; changes to patron or repeticiones after the start SHALL have no effect on the transfer in progress.
REQ-019 Outside ENVIO, salida SHALL be 0.
REQ-020 Latency SHALL be exactly 1 cycle from the start edge to the first valid bit; a transfer SHALL take R*W + (R-1)*PAUSA + 1 cycles to the fin cycle inclusive, where W is the bits per word and R is the effective repetition count.
REQ-021 The bit counter SHALL be ceil(log2(ANCHO+1)) bits wide; the repetition counter SHALL be 5 bits wide so that no wrap-around occurs.

Reset
REQ-022 With rst=1 at an edge, SHALL force state REPOSO and drive salida=0, valido=0, ocupado=0 and fin=0 on the following cycle.
REQ-023 Reset SHALL override iniciar presented in the same cycle.
REQ-024 Reset during any state SHALL abort the transfer without asserting fin.
REQ-025 The latched pattern and counters need no reset value, but SHALL be reloaded on the next accepted start.

Configuration
REQ-026 With GEN_PARIDAD_EN defined, SHALL append one even-parity bit (XOR of the latched pattern) after each word, with valido=1.
REQ-027 Without GEN_PARIDAD_EN, SHALL send words of exactly ANCHO bits and contain no parity logic.

Structure
REQ-028 State encodings (REPOSO=0, ENVIO=1, PAUSA=2, FIN=3) and the default pattern constant PATRON_DEF = 4'b1011 SHALL reside in the shared package paquete_patrones, which the receiver also uses.
REQ-029 The shift register and bit counter SHALL be a sub-module registro_desplazamiento with ports load, shift, data and msb.

Verification
REQ-030 Scenario: start at edge N with patron=1011, repeticiones=1, PAUSA=1, no parity -> salida=1,0,1,1 with valido=1 at cycles N+1..N+4, fin=1 at N+5, ocupado=0 at N+6.
REQ-031 Scenario: patron=1011, repeticiones=2, PAUSA=1 -> 1011, then 1 idle cycle with valido=0, then 1011, then fin; total 10 cycles.
REQ-032 Scenario: repeticiones=0 -> identical output to repeticiones=1.
REQ-033 Scenario: with GEN_PARIDAD_EN, patron=1011 -> salida=1,0,1,1,1 with valido=1 for 5 cycles.
REQ-034 Scenario: rst asserted during the third bit -> next cycle all outputs are 0, fin never pulses, and a new start is accepted normally.
REQ-035 Scenario: iniciar pulsed mid-transfer and patron changed to 0000 -> the output is unchanged and no second transfer occurs.
